// File: rtl/window_stream_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// master = pixel source and window consumer side, slave = the generator.
interface window_stream_3x3_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_w0;
  logic [PIX_W-1:0] out_w1;
  logic [PIX_W-1:0] out_w2;
  logic [PIX_W-1:0] out_w3;
  logic [PIX_W-1:0] out_w4;
  logic [PIX_W-1:0] out_w5;
  logic [PIX_W-1:0] out_w6;
  logic [PIX_W-1:0] out_w7;
  logic [PIX_W-1:0] out_w8;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
  logic             frame_err;
  logic             clr_err;

  modport master (
    output in_valid, in_pixel, in_sof, out_ready, clr_err,
    input  in_ready, out_valid, out_w0, out_w1, out_w2, out_w3, out_w4,
           out_w5, out_w6, out_w7, out_w8, out_sof, out_eol, out_eof, frame_err
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, out_ready, clr_err,
    output in_ready, out_valid, out_w0, out_w1, out_w2, out_w3, out_w4,
           out_w5, out_w6, out_w7, out_w8, out_sof, out_eol, out_eof, frame_err
  );
endinterface

// File: rtl/window_stream_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// window, one window per interior pixel, single registered output stage.
module window_stream_3x3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  window_stream_3x3_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    col, cur_col, nxt_col;
  logic [RW-1:0]    row, cur_row, nxt_row;
  logic             col_last, row_last;
  logic             accept, emit, err_set;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win     [9];
  logic [PIX_W-1:0] win_nxt [9];
  logic [PIX_W-1:0] ow      [9];
  logic             ov, osof, oeol, oeof, ferr;

  assign bus.in_ready = !ov || bus.out_ready;

  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    // in_sof re-indexes the accepted pixel as (0,0)
    cur_col  = bus.in_sof ? '0 : col;
    cur_row  = bus.in_sof ? '0 : row;
    col_last = (cur_col == CW'(IMG_W - 1));
    row_last = (cur_row == RW'(IMG_H - 1));
    nxt_col  = col_last ? '0 : cur_col + CW'(1);
    nxt_row  = cur_row;
    if (col_last) nxt_row = row_last ? '0 : cur_row + RW'(1);
    emit     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    err_set  = accept && bus.in_sof && ((col != '0) || (row != '0));
    for (int i = 0; i < 3; i++) begin
      win_nxt[3*i]   = win[3*i+1];
      win_nxt[3*i+1] = win[3*i+2];
    end
    win_nxt[2] = lb0[cur_col];
    win_nxt[5] = lb1[cur_col];
    win_nxt[8] = bus.in_pixel;
  end

  // Line buffers carry no reset; rows 0 and 1 of every frame rewrite them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      ov   <= 1'b0;
      osof <= 1'b0;
      oeol <= 1'b0;
      oeof <= 1'b0;
      ferr <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
        ow[i]  <= '0;
      end
    end else begin
      if (accept) begin
        col <= nxt_col;
        row <= nxt_row;
        for (int i = 0; i < 9; i++) win[i] <= win_nxt[i];
      end
      if (accept && emit) begin
        ov   <= 1'b1;
        osof <= (cur_row == RW'(2)) && (cur_col == CW'(2));
        oeol <= col_last;
        oeof <= col_last && row_last;
        for (int i = 0; i < 9; i++) ow[i] <= win_nxt[i];
      end else if (bus.out_ready) begin
        ov <= 1'b0;
      end
      if (err_set)          ferr <= 1'b1;
      else if (bus.clr_err) ferr <= 1'b0;
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_sof   = osof;
  assign bus.out_eol   = oeol;
  assign bus.out_eof   = oeof;
  assign bus.frame_err = ferr;
  assign bus.out_w0    = ow[0];
  assign bus.out_w1    = ow[1];
  assign bus.out_w2    = ow[2];
  assign bus.out_w3    = ow[3];
  assign bus.out_w4    = ow[4];
  assign bus.out_w5    = ow[5];
  assign bus.out_w6    = ow[6];
  assign bus.out_w7    = ow[7];
  assign bus.out_w8    = ow[8];
endmodule

// File: tb/tb_window_stream_3x3.sv
// Scoreboard bench: a 5x4 instance driven by directed frames and a 64x64
// instance driven by a ramp; a negedge monitor pops expected windows.
`timescale 1ns/1ps
module tb_window_stream_3x3;
  localparam int PW = 8;
  localparam int SW = 5;
  localparam int SH = 4;
  localparam int LW = 64;
  localparam int LH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_stream_3x3_if #(.PIX_W(PW)) sb ();
  window_stream_3x3_if #(.PIX_W(PW)) lb ();

  window_stream_3x3 #(.PIX_W(PW), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(sb));
  window_stream_3x3 #(.PIX_W(PW), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(lb));

  typedef struct packed {
    logic [8:0][PW-1:0] w;
    logic sof;
    logic eol;
    logic eof;
  } win_t;

  win_t exp_q[$];
  win_t got_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mr = 0;
  int   mc = 0;
  logic [PW-1:0] img [SH][SW];
  logic mon_skip   = 1'b0;
  logic rdy_toggle = 1'b0;
  logic rdy_level  = 1'b1;

  // out_ready of the small instance: fixed level or toggling every cycle
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) sb.out_ready = ~sb.out_ready;
    else            sb.out_ready = rdy_level;
  end

  function automatic win_t cur_s();
    win_t c;
    c.w[0] = sb.out_w0; c.w[1] = sb.out_w1; c.w[2] = sb.out_w2;
    c.w[3] = sb.out_w3; c.w[4] = sb.out_w4; c.w[5] = sb.out_w5;
    c.w[6] = sb.out_w6; c.w[7] = sb.out_w7; c.w[8] = sb.out_w8;
    c.sof = sb.out_sof; c.eol = sb.out_eol; c.eof = sb.out_eof;
    return c;
  endfunction

  win_t prev_out;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    win_t cur, e;
    cur = cur_s();
    if (mon_skip) begin
      prev_stall = 1'b0;
      mon_skip   = 1'b0;
    end else if (rst_n) begin
      if (prev_stall) begin
        n_tests++;
        if (!sb.out_valid || cur !== prev_out) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b %h, required valid=1 %h", sb.out_valid, cur, prev_out);
        end
      end
      if (sb.out_valid && sb.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL window_extra: got %h, required no window", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL window: got %h, required %h", cur, e);
          end
        end
        got_q.push_back(cur);
      end
      prev_stall = sb.out_valid && !sb.out_ready;
      prev_out   = cur;
    end
  end

  // Frame-store reference: expected window taken straight from the stored image
  task automatic model_accept(input logic [PW-1:0] p, input logic sof);
    win_t e;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 9; i++) e.w[i] = img[mr-2+i/3][mc-2+i%3];
      e.sof = (mr == 2 && mc == 2);
      e.eol = (mc == SW-1);
      e.eof = (mr == SH-1 && mc == SW-1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == SW) begin
      mc = 0;
      mr++;
      if (mr == SH) mr = 0;
    end
  endtask

  task automatic send_pix(input logic [PW-1:0] p, input logic sof, input int gap);
    logic acc;
    sb.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
    sb.in_valid = 1'b1;
    sb.in_pixel = p;
    sb.in_sof   = sof;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = sb.in_ready;
      @(posedge clk); #2;
    end
    sb.in_valid = 1'b0;
    sb.in_sof   = 1'b0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
    end else begin
      model_accept(p, sof);
    end
  endtask

  task automatic send_frame(input int off, input logic sof, input int gap_max);
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        send_pix(PW'(off + 5*r + c), sof && r == 0 && c == 0,
                 gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || sb.out_valid) && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d windows missing, required 0", exp_q.size());
    end
  endtask

  function automatic win_t mk(input int v[9], input logic s, input logic l, input logic f);
    win_t w;
    for (int i = 0; i < 9; i++) w.w[i] = PW'(v[i]);
    w.sof = s; w.eol = l; w.eof = f;
    return w;
  endfunction

  task automatic chk_win(input string nm, input int idx, input win_t e);
    n_tests++;
    if (idx >= got_q.size()) begin
      n_fail++;
      $display("FAIL %s: got only %0d windows, required index %0d", nm, got_q.size(), idx);
    end else if (got_q[idx] !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got_q[idx], e);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  // 64x64 ramp monitor: window k sits at r = k/62+2, c = k%62+2, pixel = (64r+c) mod 256
  int l_cnt = 0;
  int l_eol = 0;
  int l_eof = 0;
  always @(negedge clk) begin
    int r, c;
    logic [3*PW+2:0] got, req;
    if (rst_n && lb.out_valid && lb.out_ready) begin
      r = l_cnt / (LW-2) + 2;
      c = l_cnt % (LW-2) + 2;
      got = {lb.out_w0, lb.out_w4, lb.out_w8, lb.out_sof, lb.out_eol, lb.out_eof};
      req = {PW'((r-2)*LW + c-2), PW'((r-1)*LW + c-1), PW'(r*LW + c),
             l_cnt == 0, c == LW-1, l_cnt == (LW-2)*(LH-2)-1};
      n_tests++;
      if (got !== req) begin
        n_fail++;
        $display("FAIL ramp_window %0d: got %h, required %h", l_cnt, got, req);
      end
      l_cnt++;
      if (lb.out_eol) l_eol++;
      if (lb.out_eof) l_eof++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hw[9];
    sb.in_valid = 0; sb.in_pixel = 0; sb.in_sof = 0; sb.clr_err = 0;
    lb.in_valid = 0; lb.in_pixel = 0; lb.in_sof = 0; lb.clr_err = 0; lb.out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    chk_int("rst_out_valid", int'(sb.out_valid), 0);
    chk_int("rst_in_ready", int'(sb.in_ready), 1);
    chk_int("rst_frame_err", int'(sb.frame_err), 0);
    chk_int("rst_window_zero", int'(cur_s() == '0), 1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // single 5x4 frame, out_ready held high
    got_q.delete();
    send_frame(0, 1'b1, 0);
    drain();
    chk_int("frame1_count", got_q.size(), 6);
    hw = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    chk_win("frame1_first", 0, mk(hw, 1'b1, 1'b0, 1'b0));
    hw = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    chk_win("frame1_last", 5, mk(hw, 1'b0, 1'b1, 1'b1));
    chk_int("sof_at_origin_no_err", int'(sb.frame_err), 0);

    // same frame under toggling out_ready and random input gaps
    got_q.delete();
    rdy_toggle = 1'b1;
    send_frame(0, 1'b1, 2);
    drain();
    rdy_toggle = 1'b0;
    rdy_level  = 1'b1;
    @(posedge clk); #2;
    chk_int("stall_count", got_q.size(), 6);
    hw = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    chk_win("stall_first", 0, mk(hw, 1'b1, 1'b0, 1'b0));

    // back-to-back frames, second without in_sof
    got_q.delete();
    send_frame(0, 1'b1, 0);
    send_frame(100, 1'b0, 0);
    drain();
    chk_int("b2b_count", got_q.size(), 12);
    hw = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
    chk_win("b2b_frame2_first", 6, mk(hw, 1'b1, 1'b0, 1'b0));
    hw = '{107, 108, 109, 112, 113, 114, 117, 118, 119};
    chk_win("b2b_frame2_last", 11, mk(hw, 1'b0, 1'b1, 1'b1));

    // in_sof at (1,3) restarts the frame and flags an error
    got_q.delete();
    for (int i = 0; i < 8; i++) send_pix(PW'(i), i == 0, 0);
    send_frame(50, 1'b1, 0);
    drain();
    chk_int("sof_err_set", int'(sb.frame_err), 1);
    chk_int("sof_err_count", got_q.size(), 6);
    hw = '{50, 51, 52, 55, 56, 57, 60, 61, 62};
    chk_win("sof_err_first", 0, mk(hw, 1'b1, 1'b0, 1'b0));
    sb.clr_err = 1'b1;
    @(posedge clk); #2;
    sb.clr_err = 1'b0;
    chk_int("clr_err", int'(sb.frame_err), 0);

    // reset mid row 3 with a window held by backpressure
    for (int i = 0; i < 17; i++) send_pix(PW'(i), i == 0, 0);
    rdy_level = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    send_pix(PW'(17), 1'b0, 0);
    chk_int("pre_rst_valid", int'(sb.out_valid), 1);
    #1;
    mon_skip = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_int("midrst_out_valid", int'(sb.out_valid), 0);
    chk_int("midrst_window_zero", int'(cur_s() == '0), 1);
    chk_int("midrst_in_ready", int'(sb.in_ready), 1);
    exp_q.delete();
    got_q.delete();
    mr = 0;
    mc = 0;
    rdy_level = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    send_frame(0, 1'b0, 0);
    drain();
    chk_int("after_rst_count", got_q.size(), 6);
    hw = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    chk_win("after_rst_first", 0, mk(hw, 1'b1, 1'b0, 1'b0));

    // 64x64 ramp on the default-size instance
    for (int i = 0; i < LW*LH; i++) begin
      lb.in_valid = 1'b1;
      lb.in_pixel = PW'(i);
      lb.in_sof   = (i == 0);
      @(negedge clk);
      if (!lb.in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL ramp_in_ready: got 0 at pixel %0d, required 1", i);
      end
      @(posedge clk); #2;
    end
    lb.in_valid = 1'b0;
    lb.in_sof   = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    chk_int("ramp_count", l_cnt, (LW-2)*(LH-2));
    chk_int("ramp_eol_count", l_eol, LH-2);
    chk_int("ramp_eof_count", l_eof, 1);
    chk_int("ramp_frame_err", int'(lb.frame_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/window_stream_3x3.md
# window_stream_3x3

Streaming 3x3 neighbourhood generator: accepts a raster-order pixel stream of an IMG_W x IMG_H frame and emits one 3x3 window per fully-interior position, giving (IMG_W-2) x (IMG_H-2) windows per frame. Two IMG_W-deep line buffers replace the full-frame read memory of the previous generation. Valid/ready handshakes on both sides, frame markers, and a sticky framing error flag. Sits between the pixel source and the 3x3 convolution datapath.

## Interface
- PIX_W, 8, pixel width in bits
- IMG_W, 64, frame width in pixels (>= 3)
- IMG_H, 64, frame height in pixels (>= 3)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input pixel valid
- in_ready  output  1  block can accept a pixel
- in_pixel  input  PIX_W  input pixel
- in_sof  input  1  marks first pixel of a frame (qualified by in_valid)
- out_valid  output  1  window valid
- out_ready  input  1  consumer accepts window
- out_w0..out_w8  output  PIX_W each  window, row-major; w0 = (r-2,c-2), w4 = centre (r-1,c-1), w8 = (r,c)
- out_sof  output  1  first window of frame
- out_eol  output  1  last window of an output row
- out_eof  output  1  last window of frame
- frame_err  output  1  sticky framing error
- clr_err  input  1  synchronous clear of frame_err

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (single output stage).
- Counters col (clog2(IMG_W) bits), row (clog2(IMG_H) bits) give position (r,c) of the accepted pixel. On accept: col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0 at frame end.
- Line buffers: LB1[c] holds row r-1, LB0[c] holds row r-2. On accept at column c: read LB1[c], LB0[c]; write LB0[c] <= old LB1[c], LB1[c] <= in_pixel.
- Window shift register (3x3): on accept, columns shift left; new right column = {LB0[c], LB1[c], in_pixel} (top to bottom).
- Window emitted when accepted pixel has r >= 2 and c >= 2: out_w* loaded from post-shift window, out_valid set. Pixels with r < 2 or c < 2 update state only.
- Flags for emitted window: out_sof = (r==2 && c==2); out_eol = (c==IMG_W-1); out_eof = (r==IMG_H-1 && c==IMG_W-1).
- in_sof on an accepted pixel: that pixel is treated as (0,0) (counters forced). If counters were not already at (0,0), frame_err sets. in_sof absent at (0,0) is not an error.
- frame_err: set wins over clr_err in the same cycle.
- out_valid clears on out_ready with no new window loaded; accept and drain in the same cycle loads the new window (out_valid stays 1).

## Timing
- Reset (async): out_valid 0, out_w0..out_w8 0, out_sof/eol/eof 0, frame_err 0, row 0, col 0, window registers 0. Line buffer contents undefined; never emitted before being rewritten by two rows.
- in_ready is 1 out of reset.
- Latency: window for pixel (r,c) visible on out_* the cycle after that pixel is accepted.
- Throughput: one pixel per cycle, one window per cycle in steady state with out_ready held 1.
- Backpressure: out_valid && !out_ready -> in_ready 0; out_* and all state held stable.
- Reset asserted mid-frame: all of the above return to reset values immediately; next accepted pixel is (0,0).
- Single-frame stream without in_sof: counters wrap and next frame starts at (0,0) automatically.

## Test plan
- IMG_W=5, IMG_H=4, pixel = 5r+c, in_sof on first, out_ready=1 -> exactly 6 windows; first = {0,1,2,5,6,7,10,11,12} with out_sof; last = {7,8,9,12,13,14,17,18,19} with out_eol and out_eof.
- Same frame, out_ready toggling 1/0 each cycle and random in_valid gaps -> identical 6-window sequence, no loss/duplication, out_* stable while stalled.
- Two back-to-back frames, second pixel values +100 -> second frame windows all from second-frame pixels, out_sof on window 7.
- in_sof asserted at pixel (1,3) of a 5x4 frame -> frame_err=1, that pixel re-indexed as (0,0), next 6 windows correct relative to it; clr_err pulse -> frame_err=0.
- rst_n low mid-row 3 with out_valid=1 -> out_valid 0, out_w* 0 immediately; restarted frame yields correct first window.
- Default 64x64, ramp stream -> 3844 windows, out_eol every 62, single out_eof.
